// File: rtl/v_storeunit_param.sv
// Vector store data unit: captures a register group and streams NUM_BANKS
// elements per accepted beat to the banks, with vl limit, masking and strides.

`ifndef DATAMEM_BITS
`define DATAMEM_BITS 16
`endif
`ifndef DATAMEM_WIDTH
`define DATAMEM_WIDTH 32
`endif

module v_storeunit_lane #(
    parameter int DATA_W        = 512,
    parameter int MAX_ELEMS     = 64,
    parameter int VLW           = 7,
    parameter int DATAMEM_BITS  = 16,
    parameter int DATAMEM_WIDTH = 32
) (
    input  logic [VLW:0]               idx,
    input  logic                       strided,
    input  logic [1:0]                 vsew,
    input  logic [VLW-1:0]             vl,
    input  logic [DATAMEM_BITS-1:0]    base_addr,
    input  logic [DATAMEM_BITS-1:0]    stride,
    input  logic [DATA_W-1:0]          data,
    input  logic                       mask_en,
    input  logic [MAX_ELEMS-1:0]       mask,
    output logic [DATAMEM_BITS-1:0]    addr,
    output logic [DATAMEM_WIDTH-1:0]   wdata,
    output logic                       we
);
    logic [7:0]              e8;
    logic [15:0]             e16;
    logic [31:0]             e32;
    logic [31:0]             ext;
    logic                    mask_hit;
    logic [DATAMEM_BITS-1:0] idx_b;
    logic [DATAMEM_BITS-1:0] offset;

    // Element select by index compare; indices past the group read as zero.
    always_comb begin
        e8       = '0;
        e16      = '0;
        e32      = '0;
        mask_hit = 1'b0;
        for (int j = 0; j < DATA_W/8; j++) begin
            if (idx == (VLW+1)'(j)) begin
                e8       = data[j*8 +: 8];
                mask_hit = mask[j];
            end
        end
        for (int j = 0; j < DATA_W/16; j++)
            if (idx == (VLW+1)'(j)) e16 = data[j*16 +: 16];
        for (int j = 0; j < DATA_W/32; j++)
            if (idx == (VLW+1)'(j)) e32 = data[j*32 +: 32];
        case (vsew)
            2'b00:   ext = {{24{e8[7]}}, e8};
            2'b01:   ext = {{16{e16[15]}}, e16};
            default: ext = e32;
        endcase
    end

    assign wdata  = DATAMEM_WIDTH'($signed(ext));
    assign idx_b  = DATAMEM_BITS'(idx);
    // Low bits of the product are sign-agnostic, so a negative stride wraps correctly.
    assign offset = strided ? idx_b * stride : idx_b;
    assign addr   = base_addr + offset;
    assign we     = ({1'b0, vl} > idx) && (!mask_en || mask_hit);
endmodule

module v_storeunit_param #(
    parameter int VLEN          = 128,
    parameter int MAX_LMUL      = 4,
    parameter int NUM_BANKS     = 4,
    parameter int DATAMEM_BITS  = `DATAMEM_BITS,
    parameter int DATAMEM_WIDTH = `DATAMEM_WIDTH,
    localparam int DATA_W       = VLEN*MAX_LMUL,
    localparam int MAX_ELEMS    = DATA_W/8,
    localparam int VLW          = $clog2(MAX_ELEMS+1)
) (
    input  logic                                 clk,
    input  logic                                 rst,
    input  logic                                 start,
    input  logic                                 strided,
    input  logic [1:0]                           vsew,
    input  logic [VLW-1:0]                       vl,
    input  logic [DATAMEM_BITS-1:0]              base_addr,
    input  logic [DATAMEM_BITS-1:0]              stride,
    input  logic [DATA_W-1:0]                    data,
    input  logic                                 mask_en,
    input  logic [MAX_ELEMS-1:0]                 mask,
    input  logic                                 mem_ready,
    output logic [NUM_BANKS*DATAMEM_BITS-1:0]    data_addr,
    output logic [NUM_BANKS*DATAMEM_WIDTH-1:0]   data_out,
    output logic [NUM_BANKS-1:0]                 data_we,
    output logic                                 busy,
    output logic                                 done
);
    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] STORE = 2'd1;
    localparam logic [1:0] FIN   = 2'd2;

    logic [1:0]              state;
    logic                    strided_r;
    logic [1:0]              vsew_r;
    logic [VLW-1:0]          vl_r;
    logic [DATAMEM_BITS-1:0] base_r;
    logic [DATAMEM_BITS-1:0] stride_r;
    logic [DATA_W-1:0]       data_r;
    logic                    mask_en_r;
    logic [MAX_ELEMS-1:0]    mask_r;
    logic [VLW-1:0]          cnt;

    logic [NUM_BANKS-1:0][DATAMEM_BITS-1:0]  addr_q, addr_n;
    logic [NUM_BANKS-1:0][DATAMEM_WIDTH-1:0] wdata_q, wdata_n;
    logic [NUM_BANKS-1:0]                    we_q, we_n;

    // In IDLE beat 0 is built straight from the ports so it appears the cycle after start.
    logic                    idle;
    logic                    s_strided;
    logic [1:0]              s_vsew;
    logic [VLW-1:0]          s_vl;
    logic [DATAMEM_BITS-1:0] s_base;
    logic [DATAMEM_BITS-1:0] s_stride;
    logic [DATA_W-1:0]       s_data;
    logic                    s_mask_en;
    logic [MAX_ELEMS-1:0]    s_mask;
    logic [VLW:0]            cnt_next;
    logic [VLW:0]            beat_idx;
    logic                    last;

    assign idle      = (state == IDLE);
    assign s_strided = idle ? strided   : strided_r;
    assign s_vsew    = idle ? vsew      : vsew_r;
    assign s_vl      = idle ? vl        : vl_r;
    assign s_base    = idle ? base_addr : base_r;
    assign s_stride  = idle ? stride    : stride_r;
    assign s_data    = idle ? data      : data_r;
    assign s_mask_en = idle ? mask_en   : mask_en_r;
    assign s_mask    = idle ? mask      : mask_r;

    assign cnt_next  = {1'b0, cnt} + (VLW+1)'(NUM_BANKS);
    assign beat_idx  = idle ? '0 : cnt_next;
    assign last      = cnt_next >= {1'b0, vl_r};

    for (genvar k = 0; k < NUM_BANKS; k++) begin : g_lane
        v_storeunit_lane #(
            .DATA_W(DATA_W), .MAX_ELEMS(MAX_ELEMS), .VLW(VLW),
            .DATAMEM_BITS(DATAMEM_BITS), .DATAMEM_WIDTH(DATAMEM_WIDTH)
        ) u_lane (
            .idx       (beat_idx + (VLW+1)'(k)),
            .strided   (s_strided),
            .vsew      (s_vsew),
            .vl        (s_vl),
            .base_addr (s_base),
            .stride    (s_stride),
            .data      (s_data),
            .mask_en   (s_mask_en),
            .mask      (s_mask),
            .addr      (addr_n[k]),
            .wdata     (wdata_n[k]),
            .we        (we_n[k])
        );
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            strided_r <= 1'b0;
            vsew_r    <= 2'b00;
            vl_r      <= '0;
            base_r    <= '0;
            stride_r  <= '0;
            data_r    <= '0;
            mask_en_r <= 1'b0;
            mask_r    <= '0;
            cnt       <= '0;
            addr_q    <= '0;
            wdata_q   <= '0;
            we_q      <= '0;
        end else begin
            case (state)
                IDLE: if (start) begin
                    strided_r <= strided;
                    vsew_r    <= vsew;
                    vl_r      <= vl;
                    base_r    <= base_addr;
                    stride_r  <= stride;
                    data_r    <= data;
                    mask_en_r <= mask_en;
                    mask_r    <= mask;
                    cnt       <= '0;
                    if (vl == '0) begin
                        state <= FIN;
                        we_q  <= '0;
                    end else begin
                        state   <= STORE;
                        addr_q  <= addr_n;
                        wdata_q <= wdata_n;
                        we_q    <= we_n;
                    end
                end
                STORE: if (mem_ready) begin
                    if (last) begin
                        state <= FIN;
                        we_q  <= '0;
                    end else begin
                        cnt     <= cnt_next[VLW-1:0];
                        addr_q  <= addr_n;
                        wdata_q <= wdata_n;
                        we_q    <= we_n;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign data_addr = addr_q;
    assign data_out  = wdata_q;
    assign data_we   = we_q;
    assign busy      = (state != IDLE);
    assign done      = (state == FIN);
endmodule

// File: tb/tb_v_storeunit_param.sv
// Bench for v_storeunit_param: directed and random stores checked beat by beat
// against an element-level model of addresses, data and write enables.

module tb_v_storeunit_param;
    localparam int NB     = 4;
    localparam int B      = 16;
    localparam int W      = 32;
    localparam int DATA_W = 512;
    localparam int ME     = 64;
    localparam int VLW    = 7;

    logic              clk, rst, start, strided, mask_en, mem_ready;
    logic [1:0]        vsew;
    logic [VLW-1:0]    vl;
    logic [B-1:0]      base_addr, stride;
    logic [DATA_W-1:0] data;
    logic [ME-1:0]     mask;
    logic [NB*B-1:0]   data_addr;
    logic [NB*W-1:0]   data_out;
    logic [NB-1:0]     data_we;
    logic              busy, done;

    v_storeunit_param #(
        .VLEN(128), .MAX_LMUL(4), .NUM_BANKS(NB), .DATAMEM_BITS(B), .DATAMEM_WIDTH(W)
    ) dut (
        .clk(clk), .rst(rst), .start(start), .strided(strided), .vsew(vsew), .vl(vl),
        .base_addr(base_addr), .stride(stride), .data(data), .mask_en(mask_en),
        .mask(mask), .mem_ready(mem_ready), .data_addr(data_addr), .data_out(data_out),
        .data_we(data_we), .busy(busy), .done(done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    // Operation as the model sees it; the ports are scrambled after start.
    logic              e_strided, e_mask_en;
    logic [1:0]        e_sew;
    int                e_vl;
    logic [B-1:0]      e_base, e_stride;
    logic [DATA_W-1:0] e_data;
    logic [ME-1:0]     e_mask;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic int sew_bits();
        return (e_sew == 2'b00) ? 8 : (e_sew == 2'b01) ? 16 : 32;
    endfunction

    function automatic logic [B-1:0] exp_addr(input int i);
        longint s, a;
        s = longint'(e_stride);
        if (s >= (64'd1 << (B-1))) s -= (64'd1 << B);
        a = longint'(e_base) + longint'(i) * (e_strided ? s : 64'd1);
        return B'(a);
    endfunction

    function automatic logic [W-1:0] exp_data(input int i);
        int sb;
        logic [DATA_W-1:0] sh;
        longint v;
        sb = sew_bits();
        sh = e_data >> (i*sb);
        v  = longint'(sh[31:0]) & ((64'd1 << sb) - 1);
        if (v >= (64'd1 << (sb-1))) v -= (64'd1 << sb);
        return W'(v);
    endfunction

    function automatic logic exp_we(input int i);
        return (i < e_vl) && (!e_mask_en || e_mask[i]);
    endfunction

    task automatic check_beat(input int b);
        for (int k = 0; k < NB; k++) begin
            int i;
            i = b*NB + k;
            chk($sformatf("addr b%0d l%0d", b, k), 64'(data_addr[k*B +: B]), 64'(exp_addr(i)));
            chk($sformatf("data b%0d l%0d", b, k), 64'(data_out[k*W +: W]), 64'(exp_data(i)));
            chk($sformatf("we b%0d l%0d", b, k), 64'(data_we[k]), 64'(exp_we(i)));
        end
        chk("busy in store", 64'(busy), 64'd1);
        chk("done in store", 64'(done), 64'd0);
    endtask

    task automatic drive_op();
        strided = e_strided; vsew = e_sew; vl = VLW'(e_vl); base_addr = e_base;
        stride = e_stride; data = e_data; mask_en = e_mask_en; mask = e_mask;
    endtask

    task automatic scramble();
        strided = 1'($urandom); vsew = 2'($urandom); vl = VLW'($urandom);
        base_addr = B'($urandom); stride = B'($urandom); mask_en = 1'($urandom);
        mask = {$urandom, $urandom};
        for (int j = 0; j < DATA_W/32; j++) data[j*32 +: 32] = $urandom;
    endtask

    task automatic rand_op();
        int maxvl;
        e_sew = 2'($urandom_range(0, 3));
        maxvl = DATA_W / sew_bits();
        e_vl = $urandom_range(0, maxvl);
        e_strided = 1'($urandom); e_stride = B'($urandom); e_base = B'($urandom);
        e_mask_en = 1'($urandom); e_mask = {$urandom, $urandom};
        for (int j = 0; j < DATA_W/32; j++) e_data[j*32 +: 32] = $urandom;
    endtask

    task automatic run_store(input int stall_beat, input int stall_len, input int rst_beat, input bit poke);
        int nbeats, cyc, stalls;
        nbeats = (e_vl + NB - 1) / NB;
        stalls = (stall_beat >= 0 && stall_beat < nbeats) ? stall_len : 0;
        @(negedge clk);
        drive_op(); start = 1'b1; mem_ready = 1'b1;
        @(negedge clk);
        start = 1'b0; scramble(); cyc = 1;
        if (poke) start = 1'b1;
        for (int b = 0; b < nbeats; b++) begin
            if (b == stall_beat) begin
                for (int s = 0; s < stall_len; s++) begin
                    mem_ready = 1'b0;
                    check_beat(b);
                    @(negedge clk); start = 1'b0; cyc++;
                end
                mem_ready = 1'b1;
            end
            check_beat(b);
            if (b == rst_beat) begin
                rst = 1'b1;
                #1;
                chk("rst addr", 64'(data_addr), 64'd0);
                chk("rst data", 64'(data_out), 64'd0);
                chk("rst we", 64'(data_we), 64'd0);
                chk("rst busy", 64'(busy), 64'd0);
                chk("rst done", 64'(done), 64'd0);
                @(negedge clk); rst = 1'b0; start = 1'b0;
                repeat (3) begin
                    @(negedge clk);
                    chk("post-rst done", 64'(done), 64'd0);
                    chk("post-rst we", 64'(data_we), 64'd0);
                    chk("post-rst busy", 64'(busy), 64'd0);
                end
                return;
            end
            @(negedge clk); start = 1'b0; cyc++;
        end
        chk("done", 64'(done), 64'd1);
        chk("done latency", 64'(cyc), 64'(nbeats + 1 + stalls));
        chk("we in fin", 64'(data_we), 64'd0);
        chk("busy in fin", 64'(busy), 64'd1);
        @(negedge clk); start = 1'b0;
        chk("done pulse end", 64'(done), 64'd0);
        chk("idle busy", 64'(busy), 64'd0);
        @(negedge clk);
        chk("single done", 64'(done), 64'd0);
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; mem_ready = 1'b1;
        strided = 1'b0; vsew = 2'b00; vl = '0; base_addr = '0; stride = '0;
        data = '0; mask_en = 1'b0; mask = '0;
        #12;
        chk("reset addr", 64'(data_addr), 64'd0);
        chk("reset data", 64'(data_out), 64'd0);
        chk("reset we", 64'(data_we), 64'd0);
        chk("reset busy", 64'(busy), 64'd0);
        chk("reset done", 64'(done), 64'd0);
        @(negedge clk); rst = 1'b0;

        // Unit-stride 32b, one full beat.
        e_sew = 2'b10; e_vl = 4; e_base = 16'h0100; e_strided = 1'b0; e_stride = '0;
        e_mask_en = 1'b0; e_mask = '0; e_data = '0;
        e_data[127:0] = 128'h44444444_33333333_22222222_11111111;
        run_store(-1, 0, -1, 1'b0);

        // Strided 8b, stride -2, partial second beat.
        e_sew = 2'b00; e_vl = 6; e_base = 16'h0040; e_strided = 1'b1; e_stride = 16'hFFFE;
        e_data = '0;
        e_data[7:0] = 8'h81;
        for (int j = 1; j < 8; j++) e_data[j*8 +: 8] = 8'(j + 1);
        run_store(-1, 0, -1, 1'b0);

        // Masked 16b.
        e_sew = 2'b01; e_vl = 8; e_base = 16'h0200; e_strided = 1'b0;
        e_mask_en = 1'b1; e_mask = 64'hA5;
        for (int j = 0; j < DATA_W/32; j++) e_data[j*32 +: 32] = $urandom;
        run_store(-1, 0, -1, 1'b0);

        // Three-cycle stall during beat 1 of a 16-element store.
        e_sew = 2'b10; e_vl = 16; e_base = 16'hFFFA; e_mask_en = 1'b0;
        run_store(1, 3, -1, 1'b0);

        // vl = 0, then starts raised while busy.
        e_vl = 0;
        run_store(-1, 0, -1, 1'b1);
        e_sew = 2'b01; e_vl = 8; e_strided = 1'b1; e_stride = 16'h0003;
        run_store(-1, 0, -1, 1'b1);

        // Reset during beat 2 of a 64-element store, then a fresh store.
        e_sew = 2'b00; e_vl = 64; e_strided = 1'b0; e_base = 16'h1000;
        run_store(-1, 0, 2, 1'b0);
        rand_op();
        run_store(-1, 0, -1, 1'b0);

        for (int n = 0; n < 10; n++) begin
            rand_op();
            run_store($urandom_range(0, 4), $urandom_range(0, 3), -1, 1'($urandom));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
